lcd_cmd_ctrl: RTL and testbench
===============================

# lcd_cmd_ctrl

Memory-mapped character-LCD command engine on the IO side of the LSU. The core's store path writes (RS, byte) pairs into an internal FIFO. The block replays each entry onto HD44780-style LCD pins with enforced setup, enable-pulse and execution delays. Software no longer bit-banges LCD timing through the IO output register; it only writes commands and polls `o_busy`.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: command FIFO entries; power of two, ≥2.
- `T_SETUP`, 2: cycles RS/DATA are stable before EN rises; ≥1.
- `T_EN_HI`, 12: cycles EN is held high; ≥1.
- `T_CMD`, 2000: post-pulse wait for ordinary commands and data; ≥1.
- `T_CLR`, 82000: post-pulse wait for clear (0x01) and home (0x02/0x03) with RS=0; ≥1.
- `T_PWR`, 750000: power-on wait before the init sequence. Used only with `LCD_INIT_SEQ_EN`.

Ports:
- `i_clk`, in, 1: clock, rising edge.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_wr_vld`, in, 1: write request from the LSU.
- `i_wr_rs`, in, 1: 0 = command, 1 = data.
- `i_wr_data`, in, 8: byte to send.
- `o_wr_rdy`, out, 1: FIFO not full.
- `o_busy`, out, 1: FIFO non-empty, FSM not IDLE, or init in progress.
- `o_fifo_cnt`, out, $clog2(FIFO_DEPTH)+1: number of FIFO entries.
- `o_lcd_data`, out, 8: LCD data bus.
- `o_lcd_rs`, out, 1: LCD register select.
- `o_lcd_rw`, out, 1: constant 0 (write-only).
- `o_lcd_en`, out, 1: LCD enable strobe.
- `o_lcd_on`, out, 1: LCD power/backlight enable.

## Operation
- A write is accepted on a rising edge when `i_wr_vld && o_wr_rdy`. `{i_wr_rs, i_wr_data}` is pushed at the FIFO tail.
- `o_wr_rdy` comes from the registered full flag only. When the FIFO is full, no push is accepted, even if a pop happens in the same cycle.
- Writes with `i_wr_vld` high and `o_wr_rdy` low are dropped. The FIFO is unchanged.
- Simultaneous push and pop on a non-empty, non-full FIFO: `o_fifo_cnt` is unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, SETUP, PULSE, WAIT, plus PWR and INIT when the macro is enabled.
  - IDLE: if the FIFO is non-empty, pop the head, register it onto `o_lcd_rs`/`o_lcd_data`, load the counter with `T_SETUP`, and go to SETUP. Otherwise stay.
  - SETUP: EN=0. When the counter expires, go to PULSE with the counter loaded with `T_EN_HI`.
  - PULSE: EN=1. When the counter expires, EN falls and the FSM goes to WAIT. The counter is loaded with `T_CLR` if RS=0 and data ∈ {0x01, 0x02, 0x03}; otherwise with `T_CMD`.
  - WAIT: EN=0. When the counter expires, go to IDLE.
- `o_lcd_rs`/`o_lcd_data` hold their value from pop until the next pop. They never change while EN=1.
- `o_lcd_on` is 1 from the first clock edge after reset deassertion.

## Timing
- Reset values: all outputs 0. FIFO empty, `o_fifo_cnt` = 0, FSM in IDLE (PWR with the macro).
- `o_wr_rdy` rises on the first edge after reset release.
- Reset assertion mid-pulse forces `o_lcd_en` low asynchronously and discards all FIFO contents.
- Push at edge k: `o_fifo_cnt` is updated after k, and IDLE may pop at edge k+1 at the earliest.
- Pop at edge P:
  - RS/DATA are valid after P.
  - EN is high from edge P+`T_SETUP` to edge P+`T_SETUP`+`T_EN_HI`.
  - WAIT ends at edge P+`T_SETUP`+`T_EN_HI`+`T_WAIT`, where `T_WAIT` is `T_CMD` or `T_CLR`.
  - The next pop is at that edge +1, so back-to-back period = `T_SETUP`+`T_EN_HI`+`T_WAIT`+1 cycles.
- `o_busy` falls the cycle after the FSM returns to IDLE with the FIFO empty.

## Configuration
- `LCD_INIT_SEQ_EN` defined:
  - After reset, the FSM waits `T_PWR` cycles in PWR.
  - It then issues 0x38, 0x0C, 0x01, 0x06 (RS=0) in INIT, using the normal SETUP/PULSE/WAIT timing; 0x01 uses `T_CLR`.
  - User writes are still accepted into the FIFO during this time but are not popped until INIT completes.
  - `o_busy` = 1 throughout.
- `LCD_INIT_SEQ_EN` undefined: there are no PWR/INIT states. The FSM starts in IDLE and software performs initialization.

## Test plan
Bench parameters: `FIFO_DEPTH`=4, `T_SETUP`=2, `T_EN_HI`=4, `T_CMD`=10, `T_CLR`=30, `T_PWR`=20.
- Single data write RS=1, 0x41 at edge k: pop at k+1; `o_lcd_data`=0x41, RS=1; EN high for exactly 4 cycles starting at k+3; `o_busy` low at k+18.
- Write 0x01 with RS=0: EN-fall to IDLE is 30 cycles. Write 0x80 with RS=0: 10 cycles.
- Six writes on consecutive cycles: 5 are accepted (the first pops immediately, then 4 fill the FIFO) and the 6th is dropped. `o_wr_rdy` low while `o_fifo_cnt`=4. Output order matches input order, with 17-cycle spacing.
- Assert `i_reset` low two cycles into PULSE: `o_lcd_en`=0 within the same cycle; after release `o_fifo_cnt`=0 and nothing further is emitted.
- Push and pop on the same edge with `o_fifo_cnt`=2: count stays 2. With FIFO full and a pop on the same edge: the push is refused and count goes to 3.
- With `LCD_INIT_SEQ_EN`: no EN activity for 20 cycles, then exactly 0x38, 0x0C, 0x01, 0x06 with RS=0. A user byte written during PWR appears 5th.

Source files
------------

// File: rtl/lcd_cmd_ctrl.sv
// lcd_cmd_ctrl: memory-mapped HD44780-style character LCD command engine.
// The LSU pushes (RS, byte) pairs into a small FIFO. Each entry is then
// replayed onto the LCD pins with setup, enable-pulse and execution delays
// applied, so software only has to write commands and poll o_busy.
//
// Optional feature macro: LCD_INIT_SEQ_EN. When it is defined, the block
// waits T_PWR cycles after reset and then issues 0x38, 0x0C, 0x01, 0x06
// (RS=0) before serving the FIFO.
//
// Ports:
//   i_clk       rising-edge clock
//   i_reset     asynchronous active-low reset
//   i_wr_vld    write request from the LSU
//   i_wr_rs     0 = command, 1 = data
//   i_wr_data   byte to send
//   o_wr_rdy    FIFO not full (registered)
//   o_busy      FIFO non-empty, FSM active, or init in progress
//   o_fifo_cnt  number of FIFO entries
//   o_lcd_data  LCD data bus
//   o_lcd_rs    LCD register select
//   o_lcd_rw    LCD read/write, tied to write
//   o_lcd_en    LCD enable strobe
//   o_lcd_on    LCD power/backlight enable
module lcd_cmd_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_EN_HI    = 12,
  parameter int unsigned T_CMD      = 2000,
  parameter int unsigned T_CLR      = 82000,
  parameter int unsigned T_PWR      = 750000
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_wr_vld,
  input  logic                        i_wr_rs,
  input  logic [7:0]                  i_wr_data,
  output logic                        o_wr_rdy,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt,
  output logic [7:0]                  o_lcd_data,
  output logic                        o_lcd_rs,
  output logic                        o_lcd_rw,
  output logic                        o_lcd_en,
  output logic                        o_lcd_on
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENT_W   = 9;
  localparam int unsigned T_MAX_A = (T_SETUP > T_EN_HI) ? T_SETUP : T_EN_HI;
  localparam int unsigned T_MAX_B = (T_CMD > T_CLR) ? T_CMD : T_CLR;
  localparam int unsigned T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned T_MAX   = (T_MAX_C > T_PWR) ? T_MAX_C : T_PWR;
  localparam int unsigned TMR_W   = $clog2(T_MAX + 1);

`ifdef LCD_INIT_SEQ_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_WAIT  = 3'd3,
    S_PWR   = 3'd4,
    S_INIT  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_WAIT  = 3'd3
  } state_t;
`endif

  state_t             state;
  logic [TMR_W-1:0]   tmr;

  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt_nxt_c;
  logic [ENT_W-1:0]   head_c;
  logic               push_c;
  logic               pop_c;
  logic               tmr_exp_c;
  logic               slow_c;

`ifdef LCD_INIT_SEQ_EN
  logic [2:0]         init_idx;
  logic               init_done;
  logic [7:0]         init_cmd_c;
`endif

  assign o_lcd_rw = 1'b0;

  // o_wr_rdy is the registered not-full flag, so a pop cannot free a slot
  // for a push in the same cycle.
  assign push_c    = i_wr_vld && o_wr_rdy;
  assign pop_c     = (state == S_IDLE) && (o_fifo_cnt != '0);
  assign head_c    = mem[rd_ptr];
  assign tmr_exp_c = (tmr == TMR_W'(1));

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  assign slow_c = !o_lcd_rs && (o_lcd_data[7:2] == 6'd0) && (o_lcd_data[1:0] != 2'd0);

`ifdef LCD_INIT_SEQ_EN
  // Power-on initialization bytes: 8-bit bus/2 lines, display on, clear, entry mode.
  always_comb begin
    init_cmd_c = 8'h00;
    case (init_idx)
      3'd0:    init_cmd_c = 8'h38;
      3'd1:    init_cmd_c = 8'h0C;
      3'd2:    init_cmd_c = 8'h01;
      3'd3:    init_cmd_c = 8'h06;
      default: init_cmd_c = 8'h00;
    endcase
  end
`endif

  // Next FIFO occupancy.
  always_comb begin
    cnt_nxt_c = o_fifo_cnt;
    case ({push_c, pop_c})
      2'b10:   cnt_nxt_c = o_fifo_cnt + CNT_W'(1);
      2'b01:   cnt_nxt_c = o_fifo_cnt - CNT_W'(1);
      default: cnt_nxt_c = o_fifo_cnt;
    endcase
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge i_clk) begin
    if (push_c) begin
      mem[wr_ptr] <= {i_wr_rs, i_wr_data};
    end
  end

  // FIFO pointers, occupancy and ready flag.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_fifo_cnt <= '0;
      o_wr_rdy   <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      o_fifo_cnt <= cnt_nxt_c;
      o_wr_rdy   <= (cnt_nxt_c != CNT_W'(FIFO_DEPTH));
    end
  end

  // LCD sequencing FSM with registered pin outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
`ifdef LCD_INIT_SEQ_EN
      state      <= S_PWR;
      tmr        <= TMR_W'(T_PWR);
      init_idx   <= 3'd0;
      init_done  <= 1'b0;
`else
      state      <= S_IDLE;
      tmr        <= '0;
`endif
      o_lcd_en   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= 8'h00;
      o_lcd_on   <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_lcd_on <= 1'b1;
      // Includes an accepted push so busy is visible right after the write.
      o_busy   <= push_c || (o_fifo_cnt != '0) || (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (pop_c) begin
            o_lcd_rs   <= head_c[8];
            o_lcd_data <= head_c[7:0];
            tmr        <= TMR_W'(T_SETUP);
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr_exp_c) begin
            o_lcd_en <= 1'b1;
            tmr      <= TMR_W'(T_EN_HI);
            state    <= S_PULSE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_PULSE: begin
          if (tmr_exp_c) begin
            o_lcd_en <= 1'b0;
            tmr      <= slow_c ? TMR_W'(T_CLR) : TMR_W'(T_CMD);
            state    <= S_WAIT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_WAIT: begin
          if (tmr_exp_c) begin
`ifdef LCD_INIT_SEQ_EN
            state <= init_done ? S_IDLE : S_INIT;
`else
            state <= S_IDLE;
`endif
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
`ifdef LCD_INIT_SEQ_EN
        S_PWR: begin
          if (tmr_exp_c) begin
            state <= S_INIT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_INIT: begin
          if (init_idx == 3'd4) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= init_cmd_c;
            init_idx   <= init_idx + 3'd1;
            tmr        <= TMR_W'(T_SETUP);
            state      <= S_SETUP;
          end
        end
`endif
        default: begin
          o_lcd_en <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Self-checking bench for lcd_cmd_ctrl with small timing parameters.
module tb_lcd_cmd_ctrl;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned T_SETUP    = 2;
  localparam int unsigned T_EN_HI    = 4;
  localparam int unsigned T_CMD      = 10;
  localparam int unsigned T_CLR      = 30;
  localparam int unsigned T_PWR      = 20;

`ifdef LCD_INIT_SEQ_EN
  localparam int EXP_BUSY_AFTER_RST = 1;
  localparam int EXP_EMITS_AFTER_RST = 4;
`else
  localparam int EXP_BUSY_AFTER_RST = 0;
  localparam int EXP_EMITS_AFTER_RST = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_vld = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       o_wr_rdy, o_busy, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
  logic [2:0] o_fifo_cnt;
  logic [7:0] o_lcd_data;

  lcd_cmd_ctrl #(
    .FIFO_DEPTH(FIFO_DEPTH), .T_SETUP(T_SETUP), .T_EN_HI(T_EN_HI),
    .T_CMD(T_CMD), .T_CLR(T_CLR), .T_PWR(T_PWR)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_wr_vld(wr_vld), .i_wr_rs(wr_rs),
    .i_wr_data(wr_data), .o_wr_rdy(o_wr_rdy), .o_busy(o_busy),
    .o_fifo_cnt(o_fifo_cnt), .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs),
    .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // EN edge monitor: rise/fall edge numbers and the bus value at rise.
  int         rise_q [$];
  int         fall_q [$];
  logic [8:0] rise_v [$];
  logic       en_prev = 1'b0;
  logic [8:0] prev_v = 9'h0;
  int         stab_err = 0;

  always @(negedge clk) begin
    if (o_lcd_en && !en_prev) begin
      rise_q.push_back(cyc);
      rise_v.push_back({o_lcd_rs, o_lcd_data});
    end
    if (!o_lcd_en && en_prev) fall_q.push_back(cyc);
    if (o_lcd_en && en_prev && ({o_lcd_rs, o_lcd_data} != prev_v)) stab_err <= stab_err + 1;
    en_prev <= o_lcd_en;
    prev_v  <= {o_lcd_rs, o_lcd_data};
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  task automatic clr_mon();
    rise_q.delete();
    fall_q.delete();
    rise_v.delete();
  endtask

  // Drive one write cycle; k is the edge on which it was presented.
  task automatic do_write(input logic rs, input logic [7:0] d, output int k, output logic acc);
    acc     = o_wr_rdy;
    wr_vld  = 1'b1;
    wr_rs   = rs;
    wr_data = d;
    @(posedge clk);
    #1;
    k      = cyc;
    wr_vld = 1'b0;
  endtask

  task automatic wait_busy_low(input int bound, output int c);
    c = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (!o_busy) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("busy_timeout", 0, 1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         t_wait;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int   k, c, r, kk, n_acc, r0, f0;
    logic acc;
    logic accs [6];

    vecs[0] = '{1'b1, 8'h41, 10};
    vecs[1] = '{1'b0, 8'h01, 30};
    vecs[2] = '{1'b0, 8'h80, 10};
    vecs[3] = '{1'b0, 8'h02, 30};
    vecs[4] = '{1'b0, 8'h03, 30};
    vecs[5] = '{1'b0, 8'h04, 10};
    vecs[6] = '{1'b1, 8'h01, 10};
    vecs[7] = '{1'b0, 8'h00, 10};

    // Reset values.
    #12;
    check("rst_rdy", o_wr_rdy, 0);
    check("rst_busy", o_busy, 0);
    check("rst_cnt", o_fifo_cnt, 0);
    check("rst_en", o_lcd_en, 0);
    check("rst_on", o_lcd_on, 0);
    check("rst_bus", {o_lcd_rs, o_lcd_data}, 0);
    check("rst_rw", o_lcd_rw, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r = cyc;
    @(posedge clk);
    #1;
    check("rel_rdy", o_wr_rdy, 1);
    check("rel_on", o_lcd_on, 1);
    check("rel_busy", o_busy, EXP_BUSY_AFTER_RST);

`ifdef LCD_INIT_SEQ_EN
    // User byte during PWR must follow the four init commands.
    do_write(1'b1, 8'h55, kk, acc);
    check("init_user_acc", acc, 1);
    wait_busy_low(1000, c);
    check("init_emits", rise_q.size(), 5);
    if (rise_q.size() > 0) check("init_pwr_quiet", (rise_q[0] - r > 20) ? 1 : 0, 1);
    if (rise_v.size() > 0) check("init_b0", rise_v[0], 9'h038);
    if (rise_v.size() > 1) check("init_b1", rise_v[1], 9'h00C);
    if (rise_v.size() > 2) check("init_b2", rise_v[2], 9'h001);
    if (rise_v.size() > 3) check("init_b3", rise_v[3], 9'h006);
    if (rise_v.size() > 4) check("init_user", rise_v[4], 9'h155);
`endif

    // Single writes: latency, pulse width, wait length.
    for (int i = 0; i < 8; i++) begin
      wait_busy_low(1000, c);
      clr_mon();
      do_write(vecs[i].rs, vecs[i].data, k, acc);
      check($sformatf("v%0d_acc", i), acc, 1);
      wait_busy_low(200, c);
      check($sformatf("v%0d_emits", i), rise_q.size(), 1);
      r0 = (rise_q.size() > 0) ? rise_q[0] : -1000;
      f0 = (fall_q.size() > 0) ? fall_q[0] : -1000;
      check($sformatf("v%0d_en_rise", i), r0 - k, 3);
      check($sformatf("v%0d_en_width", i), f0 - r0, 4);
      if (rise_v.size() > 0) check($sformatf("v%0d_bus", i), rise_v[0], {vecs[i].rs, vecs[i].data});
      check($sformatf("v%0d_fall_to_idle", i), c - f0, vecs[i].t_wait + 1);
      check($sformatf("v%0d_busy_low", i), c - k, vecs[i].t_wait + 8);
    end

    // Six consecutive writes into a depth-4 FIFO.
    wait_busy_low(1000, c);
    clr_mon();
    n_acc = 0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      do_write(1'b1, 8'(16 + i), kk, acc);
      if (i == 0) k = kk;
      accs[i] = acc;
      if (acc) n_acc++;
      if (i == 4) begin
        check("full_cnt", o_fifo_cnt, 4);
        check("full_rdy", o_wr_rdy, 0);
      end
    end
    check("six_accepted", n_acc, 5);
    check("six_dropped", accs[5], 0);
    check("six_cnt_after_drop", o_fifo_cnt, 4);
    wait_busy_low(300, c);
    check("six_emits", rise_q.size(), 5);
    if (rise_q.size() > 0) check("six_first_rise", rise_q[0] - k, 3);
    for (int i = 0; i < 5; i++) begin
      if (i < rise_v.size()) check($sformatf("six_order%0d", i), rise_v[i], 9'h110 + i);
      if (i > 0 && i < rise_q.size()) check($sformatf("six_space%0d", i), rise_q[i] - rise_q[i-1], 17);
    end

    // Push and pop on the same edge, then a refused push on a full FIFO.
    wait_busy_low(1000, c);
    clr_mon();
    do_write(1'b1, 8'hA0, k, acc);
    do_write(1'b1, 8'hA1, kk, acc);
    do_write(1'b1, 8'hA2, kk, acc);
    wait_until(k + 17);
    check("pp_cnt_before", o_fifo_cnt, 2);
    do_write(1'b1, 8'hA3, kk, acc);
    check("pp_edge", kk - k, 18);
    check("pp_acc", acc, 1);
    check("pp_cnt_same", o_fifo_cnt, 2);
    do_write(1'b1, 8'hA4, kk, acc);
    do_write(1'b1, 8'hA5, kk, acc);
    check("pf_full_rdy", o_wr_rdy, 0);
    wait_until(k + 34);
    check("pf_cnt_before", o_fifo_cnt, 4);
    do_write(1'b1, 8'hA6, kk, acc);
    check("pf_refused", acc, 0);
    check("pf_cnt_after", o_fifo_cnt, 3);
    wait_busy_low(300, c);
    check("pp_emits", rise_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rise_v.size()) check($sformatf("pp_order%0d", i), rise_v[i], 9'h1A0 + i);
    end
    if (rise_q.size() > 1) check("pp_pop_b", rise_q[1] - k, 20);

    // Reset asserted two cycles into PULSE.
    wait_busy_low(1000, c);
    clr_mon();
    do_write(1'b1, 8'h33, k, acc);
    do_write(1'b1, 8'h34, kk, acc);
    do_write(1'b1, 8'h35, kk, acc);
    wait_until(k + 5);
    check("mr_en_before", o_lcd_en, 1);
    rst_n = 1'b0;
    #1;
    check("mr_en_async", o_lcd_en, 0);
    check("mr_cnt", o_fifo_cnt, 0);
    check("mr_rdy", o_wr_rdy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_mon();
    repeat (250) begin
      @(posedge clk);
      #1;
    end
    check("mr_emits", rise_q.size(), EXP_EMITS_AFTER_RST);
    check("mr_cnt_after", o_fifo_cnt, 0);
    check("mr_busy_after", o_busy, 0);

    check("bus_stable_while_en", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
